// File: rtl/f_stage_fetch.sv
// IF stage: owns the PC, runs the instruction-memory req/ack handshake and
// feeds {IR_F, PC4_F, valid_F} into the IF/ID register. A one-entry skid
// buffer catches a memory return that lands while ID is stalled, and
// redirects from ID take effect after the delay-slot fetch.
module f_stage_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IR_F,
    output logic [31:0] PC4_F,
    output logic        valid_F
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REQ      = 2'd1,
        S_WAIT_OUT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] skid_q, skid_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        redir_done_q, redir_done_d;

    logic        out_free;
    logic        advance;
    logic        redir_live;
    logic [31:0] redir_target;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;

    // The output register can take a new word if it is empty or being consumed.
    assign out_free     = ~valid_q | ~stall;
    // The PC moves only when the outstanding request is acknowledged.
    assign advance      = (state_q == S_REQ) & imem_ack;
    assign redir_target = redir_pc & ~32'd3;
    assign pc_plus4     = pc_q + 32'd4;
    // A stalled ID keeps asserting the same branch; once that redirect has
    // been applied to the PC it must not be applied a second time.
    assign redir_live   = redir_valid & ~redir_done_q;
    assign next_pc      = redir_live ? redir_target :
                          pend_q     ? pend_pc_q    : pc_plus4;

    // Memory port decodes from state and pc only (no stall/ack path).
    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = pc_q;
    assign IR_F      = ir_q;
    assign PC4_F     = pc4_q;
    assign valid_F   = valid_q;

    // Next-state and datapath: fetch, bubble, skid capture and skid drain.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        pc4_d      = pc4_q;
        valid_d    = valid_q;
        skid_d     = skid_q;
        skid_pc4_d = skid_pc4_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (imem_ack) begin
                    pc_d = next_pc;
                    if (out_free) begin
                        ir_d    = imem_rdata;
                        pc4_d   = pc_plus4;
                        valid_d = 1'b1;
                    end else begin
                        skid_d     = imem_rdata;
                        skid_pc4_d = pc_plus4;
                        state_d    = S_WAIT_OUT;
                    end
                end else if (out_free) begin
                    valid_d = 1'b0;
                    ir_d    = 32'd0;
                end
            end
            S_WAIT_OUT: begin
                if (out_free) begin
                    ir_d    = skid_q;
                    pc4_d   = skid_pc4_q;
                    valid_d = 1'b1;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Redirect bookkeeping: remember a target that could not be applied yet.
    always_comb begin
        pend_d       = pend_q;
        pend_pc_d    = pend_pc_q;
        redir_done_d = redir_done_q;
        if (advance) begin
            pend_d = 1'b0;
        end else if (redir_live) begin
            pend_d    = 1'b1;
            pend_pc_d = redir_target;
        end
        if (!stall) begin
            redir_done_d = 1'b0;
        end else if (advance && redir_live) begin
            redir_done_d = 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            ir_q         <= 32'd0;
            pc4_q        <= 32'd0;
            valid_q      <= 1'b0;
            skid_q       <= 32'd0;
            skid_pc4_q   <= 32'd0;
            pend_q       <= 1'b0;
            pend_pc_q    <= 32'd0;
            redir_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
            skid_q       <= skid_d;
            skid_pc4_q   <= skid_pc4_d;
            pend_q       <= pend_d;
            pend_pc_q    <= pend_pc_d;
            redir_done_q <= redir_done_d;
        end
    end

endmodule

// File: tb/tb_f_stage_fetch.sv
// Bench for f_stage_fetch: memory model with programmable latency, directed
// stimulus pushing expected fetch addresses, and a monitor that checks every
// handoff to ID against the queue.
`timescale 1ns/1ps
module tb_f_stage_fetch;

    localparam logic [31:0] KEY = 32'hC0DE_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] IR_F;
    logic [31:0] PC4_F;
    logic        valid_F;

    int          lat = 0;
    int          lat_cnt = 0;
    logic        ack_force = 1'b0;

    int          checks = 0;
    int          errors = 0;
    int          n_hand = 0;
    int          base;
    logic [31:0] exp_q[$];

    f_stage_fetch dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .redir_valid(redir_valid),
        .redir_pc   (redir_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .IR_F       (IR_F),
        .PC4_F      (PC4_F),
        .valid_F    (valid_F)
    );

    always #5 clk = ~clk;

    // Memory: word = addr ^ KEY, ack after lat extra cycles of held request.
    assign imem_rdata = imem_addr ^ KEY;
    assign imem_ack   = ack_force | (imem_req && (lat_cnt == lat));

    always @(posedge clk) begin
        if (!imem_req || imem_ack) lat_cnt <= 0;
        else                       lat_cnt <= lat_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a);
        exp_q.push_back(a);
    endtask

    task automatic mon_loop();
        logic [31:0] e;
        logic        pr;
        logic        pa;
        logic [31:0] paddr;
        pr = 1'b0; pa = 1'b0; paddr = 32'd0;
        forever begin
            @(negedge clk);
            if (reset && valid_F && !stall) begin
                n_hand++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL handoff_unexpected: got pc4=%h want none", PC4_F);
                end else begin
                    e = exp_q.pop_front();
                    $display("handoff pc4=%h ir=%h (expect fetch %h)", PC4_F, IR_F, e);
                    chk("handoff_pc4", PC4_F, e + 32'd4);
                    chk("handoff_ir", IR_F, e ^ KEY);
                end
            end
            if (!valid_F) chk("bubble_ir", IR_F, 32'd0);
            if (reset && pr && !pa && imem_req) chk("addr_stable", imem_addr, paddr);
            pr = imem_req; pa = imem_ack; paddr = imem_addr;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; stall = 1'b0; redir_valid = 1'b0; redir_pc = 32'd0;
        lat = 0; ack_force = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", valid_F, 0);
        chk("rst_ir", IR_F, 0);
        chk("rst_pc4", PC4_F, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 32'h3000);
        exp_q.delete();
        reset = 1'b1;
        base = n_hand;
    endtask

    // Run until the expected number of handoffs, then freeze ID.
    task automatic drain(input int target);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (n_hand >= target) break;
        end
        stall = 1'b1;
        chk("drain_count", n_hand, target);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    task automatic wait_addr(input logic [31:0] a, input string nm);
        for (int i = 0; i < 50 && imem_addr !== a; i++) tick();
        chk(nm, imem_addr, a);
    endtask

    initial begin
        fork
            mon_loop();
            begin
                #500000;
                $display("FAIL watchdog: got timeout want finish");
                $fatal(1);
            end
        join_none

        reset = 1'b1; stall = 1'b0; redir_valid = 1'b0; redir_pc = 32'd0;
        #2;

        // 1: zero-latency memory, back-to-back fetches
        do_reset();
        push(32'h3000); push(32'h3004); push(32'h3008); push(32'h300C);
        tick();
        chk("t1_req", imem_req, 1);
        chk("t1_addr0", imem_addr, 32'h3000);
        chk("t1_valid0", valid_F, 0);
        tick();
        chk("t1_addr1", imem_addr, 32'h3004);
        chk("t1_valid1", valid_F, 1);
        chk("t1_pc4_1", PC4_F, 32'h3004);
        tick();
        chk("t1_addr2", imem_addr, 32'h3008);
        chk("t1_pc4_2", PC4_F, 32'h3008);
        drain(base + 4);

        // 2: three-cycle memory, one valid in three cycles
        do_reset();
        lat = 2;
        push(32'h3000); push(32'h3004); push(32'h3008);
        begin
            int cnt;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (valid_F) break;
            end
            cnt = valid_F ? 1 : 0;
            repeat (8) begin
                @(negedge clk);
                if (valid_F) cnt++;
            end
            chk("t2_valid_duty", cnt, 3);
        end
        drain(base + 3);

        // 3: ack arrives during a 4-cycle stall, skid absorbs it
        do_reset();
        push(32'h3000); push(32'h3004); push(32'h3008); push(32'h300C);
        tick(); tick(); tick();
        chk("t3_pc4_pre", PC4_F, 32'h3008);
        stall = 1'b1;
        tick();
        chk("t3_req_skid", imem_req, 0);
        chk("t3_hold_pc4", PC4_F, 32'h3008);
        chk("t3_hold_valid", valid_F, 1);
        tick(); tick(); tick();
        stall = 1'b0;
        tick();
        chk("t3_skid_out", PC4_F, 32'h300C);
        chk("t3_req_back", imem_req, 1);
        chk("t3_addr_next", imem_addr, 32'h300C);
        drain(base + 4);

        // 4: redirect while delay-slot fetch is outstanding, low bits ignored
        do_reset();
        lat = 2;
        push(32'h3000); push(32'h3004); push(32'h3008); push(32'h3100); push(32'h3104);
        wait_addr(32'h3008, "t4_reach_slot");
        redir_valid = 1'b1; redir_pc = 32'h3102;
        tick();
        redir_valid = 1'b0;
        for (int i = 0; i < 50 && imem_addr === 32'h3008; i++) tick();
        chk("t4_redir_addr", imem_addr, 32'h3100);
        drain(base + 5);

        // 5: redirect held three cycles under stall, single fetch at target
        do_reset();
        push(32'h3000); push(32'h3004); push(32'h3008); push(32'h3200); push(32'h3204);
        tick(); tick(); tick();
        stall = 1'b1; redir_valid = 1'b1; redir_pc = 32'h3200;
        tick(); tick(); tick();
        stall = 1'b0; redir_valid = 1'b0;
        tick();
        chk("t5_addr_target", imem_addr, 32'h3200);
        chk("t5_slot_out", PC4_F, 32'h300C);
        tick();
        chk("t5_no_dup", imem_addr, 32'h3204);
        drain(base + 5);

        // 6: reset in the middle of a request with a late ack
        do_reset();
        lat = 2;
        push(32'h3000); push(32'h3004);
        wait_addr(32'h3008, "t6_reach");
        tick();
        reset = 1'b0; ack_force = 1'b1;
        #1;
        chk("t6_valid", valid_F, 0);
        chk("t6_ir", IR_F, 0);
        chk("t6_pc4", PC4_F, 0);
        chk("t6_req", imem_req, 0);
        chk("t6_addr", imem_addr, 32'h3000);
        tick(); tick();
        chk("t6_req_held", imem_req, 0);
        reset = 1'b1;
        tick();
        chk("t6_late_ack_valid", valid_F, 0);
        chk("t6_restart_addr", imem_addr, 32'h3000);
        ack_force = 1'b0; lat = 0;
        push(32'h3000); push(32'h3004);
        drain(base + 4);

        // 7: pc wraps from FFFF_FFFC to 0
        do_reset();
        push(32'h3000); push(32'hFFFF_FFFC); push(32'h0000_0000); push(32'h0000_0004);
        tick();
        redir_valid = 1'b1; redir_pc = 32'hFFFF_FFFF;
        tick();
        redir_valid = 1'b0;
        chk("t7_addr_top", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("t7_addr_wrap", imem_addr, 32'h0000_0000);
        chk("t7_pc4_wrap", PC4_F, 32'h0000_0000);
        drain(base + 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
